lfsr_seq_checker: RTL
=====================

LFSR_SEQ_CHECKER -- requirements
Module: lfsr_seq_checker

Interface
REQ-001 The block SHALL have parameter LOCK_COUNT, default 4, meaning the number of consecutive correct beats after seeding needed to lock (legal 1..15).
REQ-002 The block SHALL have parameter LOSS_COUNT, default 3, meaning the number of consecutive mismatches in LOCKED that drop lock (legal 1..15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port data_in, input, 4 bits: received sequence word.
REQ-006 The block SHALL have port data_valid, input, 1 bit: data_in is sampled on an edge only when this is high.
REQ-007 The block SHALL have port clr_err, input, 1 bit: synchronous clear of err_count.
REQ-008 The block SHALL have port locked, output, 1 bit: high while in LOCKED.
REQ-009 The block SHALL have port error, output, 1 bit: one-cycle pulse per mismatch while in LOCKED.
REQ-010 The block SHALL have port zero_seen, output, 1 bit: one-cycle pulse when a valid data_in equals 4'b0000.
REQ-011 The block SHALL have port err_count, output, 8 bits: saturating mismatch count.
REQ-012 The block SHALL have port expected, output, 4 bits: the word predicted for the next valid beat.

Function
REQ-013 The next-state function SHALL be nxt(x) = {x[2:0], x[3]^x[2]}: period 15, all-zero is the lock-up state.
REQ-014 All outputs SHALL be registered; error and zero_seen SHALL pulse on the edge that samples the offending beat, high for exactly one cycle.
REQ-015 With data_valid low, state, counters and expected SHALL hold, and error and zero_seen SHALL be 0.
REQ-016 The FSM SHALL have states HUNT, SYNC and LOCKED.
- HUNT, valid nonzero beat: expected <= nxt(data_in), match_cnt <= 0, go to SYNC.
- HUNT, valid zero beat: pulse zero_seen, stay in HUNT.
REQ-017 SYNC behaviour SHALL be:
- Match: expected <= nxt(data_in), match_cnt++. When match_cnt reaches LOCK_COUNT, go to LOCKED and set miss_cnt <= 0.
- Mismatch with nonzero data: reseed expected <= nxt(data_in), match_cnt <= 0, stay in SYNC.
- Mismatch with zero data: pulse zero_seen, go to HUNT.
- No error pulses and no err_count change in SYNC.
REQ-018 LOCKED behaviour SHALL be:
- Every valid beat: expected <= nxt(expected), free-running and never reseeded from data.
- Match: miss_cnt <= 0.
- Mismatch: pulse error, increment err_count, miss_cnt++. When miss_cnt reaches LOSS_COUNT, go to HUNT with locked low from that edge.
- A zero beat in LOCKED SHALL pulse zero_seen and also count as a mismatch.
REQ-019 Lock latency SHALL be: locked rises on the edge sampling the (LOCK_COUNT+1)th consecutive valid correct beat, counting the seed beat.
REQ-020 err_count SHALL saturate at 255 and not wrap.
REQ-021 If clr_err and a counted mismatch occur on the same edge, clear SHALL win and err_count SHALL be 0.
REQ-022 clr_err SHALL affect only err_count, not state or lock.

Reset
REQ-023 On a clock edge with reset high, the block SHALL go to HUNT and set locked=0, error=0, zero_seen=0, err_count=0, expected=4'b1111, match_cnt=0 and miss_cnt=0.
REQ-024 Reset SHALL take priority over all inputs, including mid-SYNC and mid-LOCKED.
REQ-025 After reset the block SHALL relock only through HUNT and SYNC.

Configuration
REQ-026 With macro LFSR_SEQ_CHECKER_ERRCNT_EN defined, err_count SHALL be implemented as specified.
REQ-027 Without LFSR_SEQ_CHECKER_ERRCNT_EN, err_count SHALL be a constant 8'h00 and clr_err ignored, with no counter flops; error pulses and all FSM behaviour SHALL be unchanged.

Verification
REQ-028 Clean lock: after reset, stream 1111,1110,1100,1000,0001,0010,... on consecutive valid cycles -> locked rises on the edge sampling 0001 (5th beat), expected=0010 afterwards, error never pulses.
REQ-029 Single error: when locked, replace one 0100 with 0101 -> one error pulse, err_count=1, expected continues 1001, and locked stays high.
REQ-030 Loss of lock: when locked, send 3 consecutive wrong words -> 3 error pulses, err_count=3, locked falls on the 3rd, state HUNT; correct stream then relocks after 5 beats.
REQ-031 Zero and stall: in HUNT send 0000 -> zero_seen pulses, no SYNC; with data_valid low for 10 cycles mid-SYNC -> no state or expected change.
REQ-032 Saturation and clear: force 300 mismatches (relocking as needed) -> err_count=255; assert clr_err with a simultaneous mismatch -> err_count=0.
REQ-033 Reset mid-LOCKED: assert reset while locked=1 -> next edge locked=0, err_count=0, expected=1111; macro-undefined build -> err_count stays 0 throughout all of the above.

Source files
------------

// File: rtl/lfsr_seq_checker.sv
// Checker for a 4-bit LFSR sequence nxt(x) = {x[2:0], x[3]^x[2]}: hunts, syncs, locks, counts mismatches.
// Define LFSR_SEQ_CHECKER_ERRCNT_EN to build the saturating err_count; otherwise err_count is tied to zero.
module lfsr_seq_checker #(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned LOSS_COUNT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] data_in,
  input  logic       data_valid,
  input  logic       clr_err,
  output logic       locked,
  output logic       error,
  output logic       zero_seen,
  output logic [7:0] err_count,
  output logic [3:0] expected
);

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_e;

  localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_CNT = 4'(LOSS_COUNT);

  function automatic logic [3:0] nxt(input logic [3:0] x);
    return {x[2:0], x[3] ^ x[2]};
  endfunction

  state_e     state_q, state_d;
  logic [3:0] expected_q, expected_d;
  logic [3:0] match_cnt_q, match_cnt_d;
  logic [3:0] miss_cnt_q, miss_cnt_d;
  logic       error_q, error_d;
  logic       zero_seen_q, zero_seen_d;
  logic       miss_evt;
  logic       is_zero;
  logic       is_match;

  assign is_zero  = (data_in == 4'b0000);
  assign is_match = (data_in == expected_q);

  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    error_d     = 1'b0;
    zero_seen_d = 1'b0;
    miss_evt    = 1'b0;
    if (data_valid) begin
      zero_seen_d = is_zero;
      unique case (state_q)
        HUNT: begin
          if (!is_zero) begin
            expected_d  = nxt(data_in);
            match_cnt_d = '0;
            state_d     = SYNC;
          end
        end
        SYNC: begin
          if (is_match) begin
            expected_d  = nxt(data_in);
            match_cnt_d = match_cnt_q + 4'd1;
            if (match_cnt_q + 4'd1 == LOCK_CNT) begin
              state_d    = LOCKED;
              miss_cnt_d = '0;
            end
          end else if (!is_zero) begin
            expected_d  = nxt(data_in);
            match_cnt_d = '0;
          end else begin
            state_d = HUNT;
          end
        end
        LOCKED: begin
          // Free-running prediction: data never reseeds once locked, so a zero beat is just a mismatch.
          expected_d = nxt(expected_q);
          if (is_match) begin
            miss_cnt_d = '0;
          end else begin
            error_d    = 1'b1;
            miss_evt   = 1'b1;
            miss_cnt_d = miss_cnt_q + 4'd1;
            if (miss_cnt_q + 4'd1 == LOSS_CNT) begin
              state_d = HUNT;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HUNT;
      expected_q  <= 4'b1111;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      error_q     <= 1'b0;
      zero_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      error_q     <= error_d;
      zero_seen_q <= zero_seen_d;
    end
  end

`ifdef LFSR_SEQ_CHECKER_ERRCNT_EN
  logic [7:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if (clr_err) begin
      err_count_d = '0;
    end else if (miss_evt && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`else
  logic clr_err_unused;
  logic miss_evt_unused;

  assign clr_err_unused  = clr_err;
  assign miss_evt_unused = miss_evt;
  assign err_count       = '0;
`endif

  assign locked    = (state_q == LOCKED);
  assign error     = error_q;
  assign zero_seen = zero_seen_q;
  assign expected  = expected_q;

endmodule
